// File: rtl/neighbor_edge_gen_pkg.sv
// Shared types and constants for neighbour-edge generation: pixel-memory entry,
// edge payload, index/timestamp types and the scan FSM states.
package neighbor_edge_gen_pkg;

   localparam int unsigned X_PIXEL        = 32;
   localparam int unsigned Y_PIXEL        = 32;
   localparam int unsigned TOT_PIXEL      = X_PIXEL * Y_PIXEL;
   localparam int unsigned PIX_ADDR_W     = $clog2(TOT_PIXEL);
   localparam int unsigned PIX_IDX_W      = PIX_ADDR_W + 2;
   localparam int unsigned MAX_DS_RANGE   = 25;
   localparam int unsigned NODE_IDX_WIDTH = 16;
   localparam int unsigned TS_WIDTH       = 24;
   localparam int unsigned MAX_NEIGHBORS  = 16;
   localparam int unsigned CAND_W         = $clog2(MAX_DS_RANGE);
   localparam int unsigned CNT_W          = $clog2(MAX_NEIGHBORS + 1);

   typedef logic [NODE_IDX_WIDTH-1:0]   node_idx_t;
   typedef logic [TS_WIDTH-1:0]         ts_t;
   typedef logic signed [PIX_IDX_W-1:0] pixel_idx_t;
   typedef logic [PIX_ADDR_W-1:0]       pix_addr_t;

   localparam ts_t TIME_WINDOW = 24'd50000;

   typedef struct packed {
      logic      occupied;
      node_idx_t node;
      ts_t       ts;
   } pix_entry_t;

   typedef struct packed {
      node_idx_t src;
      node_idx_t dst;
   } edge_s;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CHK,
      S_EMIT,
      S_FIN
   } state_e;

endpackage

// File: rtl/neighbor_edge_gen_if.sv
// Event input, pixel-memory read port, edge output and completion status of
// the neighbour-edge generator.
interface neighbor_edge_gen_if;
   import neighbor_edge_gen_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   pixel_idx_t           in_pixels [MAX_DS_RANGE];
   node_idx_t            in_node;
   ts_t                  in_ts;
   logic                 mem_rd_en;
   pix_addr_t            mem_rd_addr;
   pix_entry_t           mem_rd_data;
   logic                 edge_valid;
   logic                 edge_ready;
   node_idx_t            edge_src;
   node_idx_t            edge_dst;
   logic                 done;
   logic [CNT_W-1:0]     done_count;

   modport master (
      input  in_valid, in_pixels, in_node, in_ts, mem_rd_data, edge_ready,
      output in_ready, mem_rd_en, mem_rd_addr, edge_valid, edge_src, edge_dst,
             done, done_count
   );

   modport slave (
      output in_valid, in_pixels, in_node, in_ts, mem_rd_data, edge_ready,
      input  in_ready, mem_rd_en, mem_rd_addr, edge_valid, edge_src, edge_dst,
             done, done_count
   );

endinterface

// File: rtl/neighbor_edge_gen_time_filter.sv
// Decides whether a stored pixel entry is a live neighbour of the new event;
// age is a modular difference so a "future" timestamp reads as very old.
module neighbor_time_filter
   import neighbor_edge_gen_pkg::*;
(
   input  pix_entry_t entry,
   input  ts_t        in_ts,
   input  node_idx_t  in_node,
   output logic       hit_c
);

   ts_t age_c;

   assign age_c = in_ts - entry.ts;
   assign hit_c = entry.occupied && (age_c <= TIME_WINDOW) && (entry.node != in_node);

endmodule

// File: rtl/neighbor_edge_gen.sv
// Scans the 25 neighbour candidates of an event in L1 order, reads each valid
// pixel's last node and emits one edge per fresh neighbour, capped per event.
module neighbor_edge_gen
   import neighbor_edge_gen_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   neighbor_edge_gen_if.master bus
);

   state_e             state_q, state_d;
   logic [CAND_W-1:0]  k_q, k_d;
   logic [CNT_W-1:0]   c_q, c_d;
   edge_s              edge_q, edge_d;

   pixel_idx_t         pix_q [MAX_DS_RANGE];
   node_idx_t          node_q;
   ts_t                ts_q;

   logic               in_ready_q;
   logic               mem_rd_en_q;
   pix_addr_t          mem_rd_addr_q;
   logic               edge_valid_q;
   logic               done_q;
   logic [CNT_W-1:0]   done_count_q;

   logic               accept_c;
   logic               last_c;
   logic               hit_c;
   logic               rd_go_c;
   pixel_idx_t         rd_pix_c;

   neighbor_time_filter u_filter (
      .entry   (bus.mem_rd_data),
      .in_ts   (ts_q),
      .in_node (node_q),
      .hit_c   (hit_c)
   );

   // Next-state and datapath decode
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      c_d      = c_q;
      edge_d   = edge_q;
      accept_c = 1'b0;
      last_c   = (k_q == CAND_W'(MAX_DS_RANGE - 1));

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               accept_c = 1'b1;
               k_d      = '0;
               c_d      = '0;
               state_d  = S_RD;
            end
         end
         S_RD: begin
            if (pix_q[k_q][PIX_IDX_W-1]) begin
               if (last_c) state_d = S_FIN;
               else        k_d     = k_q + CAND_W'(1);
            end else begin
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (hit_c) begin
               edge_d.src = bus.mem_rd_data.node;
               edge_d.dst = node_q;
               state_d    = S_EMIT;
            end else if (last_c) begin
               state_d = S_FIN;
            end else begin
               k_d     = k_q + CAND_W'(1);
               state_d = S_RD;
            end
         end
         S_EMIT: begin
            if (bus.edge_ready) begin
               c_d = c_q + CNT_W'(1);
               if ((c_d == CNT_W'(MAX_NEIGHBORS)) || last_c) begin
                  state_d = S_FIN;
               end else begin
                  k_d     = k_q + CAND_W'(1);
                  state_d = S_RD;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state, so the read strobe lines
      // up with the RD cycle and data returns in CHK.
      rd_pix_c = accept_c ? bus.in_pixels[0] : pix_q[k_d];
      rd_go_c  = (state_d == S_RD) && !rd_pix_c[PIX_IDX_W-1];
   end

   // Control state and registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         k_q           <= '0;
         c_q           <= '0;
         edge_q        <= '0;
         in_ready_q    <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_rd_addr_q <= '0;
         edge_valid_q  <= 1'b0;
         done_q        <= 1'b0;
         done_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         c_q          <= c_d;
         edge_q       <= edge_d;
         in_ready_q   <= (state_d == S_IDLE);
         mem_rd_en_q  <= rd_go_c;
         edge_valid_q <= (state_d == S_EMIT);
         done_q       <= (state_d == S_FIN);
         if (rd_go_c)            mem_rd_addr_q <= pix_addr_t'(rd_pix_c);
         if (state_d == S_FIN)   done_count_q  <= c_d;
      end
   end

   // Event capture on acceptance
   always_ff @(posedge clk) begin
      if (accept_c) begin
         pix_q  <= bus.in_pixels;
         node_q <= bus.in_node;
         ts_q   <= bus.in_ts;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.mem_rd_en   = mem_rd_en_q;
   assign bus.mem_rd_addr = mem_rd_addr_q;
   assign bus.edge_valid  = edge_valid_q;
   assign bus.edge_src    = edge_q.src;
   assign bus.edge_dst    = edge_q.dst;
   assign bus.done        = done_q;
   assign bus.done_count  = done_count_q;

endmodule

// File: tb/tb_neighbor_edge_gen.sv
// Directed bench for neighbor_edge_gen with a behavioural pixel memory and
// monitors for reads, accepted edges and done pulses.
module tb_neighbor_edge_gen;
   import neighbor_edge_gen_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   neighbor_edge_gen_if bus ();

   neighbor_edge_gen dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic      mem_occ  [TOT_PIXEL];
   node_idx_t mem_node [TOT_PIXEL];
   ts_t       mem_ts   [TOT_PIXEL];

   always @(posedge clk)
      if (bus.mem_rd_en)
         bus.mem_rd_data <= '{mem_occ[bus.mem_rd_addr], mem_node[bus.mem_rd_addr],
                              mem_ts[bus.mem_rd_addr]};

   pixel_idx_t cand [MAX_DS_RANGE];
   int acc_cnt = 0, acc_cyc = 0, done_seen = 0, done_cyc = 0, done_val = -1;
   int rd_q[$], src_q[$], dst_q[$];
   int stalls = 0, stall_viol = 0, prev_src = 0, prev_dst = 0;
   bit prev_stall = 0;
   bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always @(negedge clk) begin
      if (rstn) begin
         if (bus.in_valid && bus.in_ready) begin acc_cnt++; acc_cyc = cyc; end
         if (bus.mem_rd_en) rd_q.push_back(int'(bus.mem_rd_addr));
         if (bus.edge_valid && bus.edge_ready) begin
            src_q.push_back(int'(bus.edge_src));
            dst_q.push_back(int'(bus.edge_dst));
         end
         if (prev_stall && (!bus.edge_valid || int'(bus.edge_src) != prev_src ||
                            int'(bus.edge_dst) != prev_dst))
            stall_viol++;
         prev_stall = bus.edge_valid && !bus.edge_ready;
         if (prev_stall) begin
            stalls++;
            prev_src = int'(bus.edge_src);
            prev_dst = int'(bus.edge_dst);
         end
         if (bus.done) begin done_seen++; done_cyc = cyc; done_val = int'(bus.done_count); end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < int'(TOT_PIXEL); i++) begin
         mem_occ[i] = 1'b0; mem_node[i] = '0; mem_ts[i] = '0;
      end
   endtask

   task automatic set_mem(input int x, input int y, input logic occ, input int node, input int ts);
      int idx;
      idx = y * int'(X_PIXEL) + x;
      mem_occ[idx]  = occ;
      mem_node[idx] = NODE_IDX_WIDTH'(node);
      mem_ts[idx]   = TS_WIDTH'(ts);
   endtask

   task automatic clear_obs();
      rd_q.delete(); src_q.delete(); dst_q.delete();
      stalls = 0; stall_viol = 0; done_val = -1;
   endtask

   // Candidate list in L1 order: per ring, dy ascending, then -dx before +dx.
   task automatic build_cands(input int cx, input int cy);
      int n;
      n = 0;
      for (int d = 0; d <= 3; d++) begin
         for (int dy = -d; dy <= d; dy++) begin
            int r;
            r = d - ((dy < 0) ? -dy : dy);
            for (int s = 0; s < 2; s++) begin
               int x, y;
               if (!(s == 1 && r == 0)) begin
                  x = cx + ((s == 0) ? -r : r);
                  y = cy + dy;
                  if (x >= 0 && x < int'(X_PIXEL) && y >= 0 && y < int'(Y_PIXEL))
                     cand[n] = pixel_idx_t'(y * int'(X_PIXEL) + x);
                  else
                     cand[n] = pixel_idx_t'(-1);
                  n++;
               end
            end
         end
      end
   endtask

   task automatic fill_all_cands(input int node_base, input int ts);
      for (int i = 0; i < int'(MAX_DS_RANGE); i++)
         if (cand[i] >= 0) begin
            mem_occ[int'(cand[i])]  = 1'b1;
            mem_node[int'(cand[i])] = NODE_IDX_WIDTH'(node_base + int'(cand[i]));
            mem_ts[int'(cand[i])]   = TS_WIDTH'(ts);
         end
   endtask

   task automatic run_event(input int node, input int ts, input bit bp, input int budget,
                            output bit ok);
      int base_acc, base_done;
      base_acc  = acc_cnt;
      base_done = done_seen;
      bus.in_node = NODE_IDX_WIDTH'(node);
      bus.in_ts   = TS_WIDTH'(ts);
      for (int i = 0; i < int'(MAX_DS_RANGE); i++) bus.in_pixels[i] = cand[i];
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (bp) bus.edge_ready = bp_pat[i % 4];
         if (acc_cnt != base_acc) bus.in_valid = 1'b0;
         if (done_seen != base_done) begin ok = 1'b1; break; end
      end
      bus.in_valid   = 1'b0;
      bus.edge_ready = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
      total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_mem_rd_en got=%0b exp=0", bus.mem_rd_en); end
      total++; if (bus.mem_rd_addr !== '0) begin bad++; $display("FAIL reset_mem_rd_addr got=%0d exp=0", bus.mem_rd_addr); end
      total++; if (bus.edge_valid !== 1'b0) begin bad++; $display("FAIL reset_edge_valid got=%0b exp=0", bus.edge_valid); end
      total++; if (bus.edge_src !== '0 || bus.edge_dst !== '0) begin bad++; $display("FAIL reset_edge_payload got=%0d/%0d exp=0/0", bus.edge_src, bus.edge_dst); end
      total++; if (bus.done !== 1'b0 || bus.done_count !== '0) begin bad++; $display("FAIL reset_done got=%0b/%0d exp=0/0", bus.done, bus.done_count); end
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", bus.in_ready); end
   endtask

   task automatic test_centre();
      bit ok;
      clear_mem(); clear_obs();
      set_mem(11, 10, 1'b1, 5, 1000);
      build_cands(10, 10);
      run_event(9, 1200, 1'b0, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL centre_timeout got=no_done exp=done"); end
      total++; if (done_val != 1) begin bad++; $display("FAIL centre_done_count got=%0d exp=1", done_val); end
      total++; if (src_q.size() != 1) begin bad++; $display("FAIL centre_edge_count got=%0d exp=1", src_q.size()); end
      total++; if ((src_q.size() > 0 ? src_q[0] : -1) != 5 || (dst_q.size() > 0 ? dst_q[0] : -1) != 9) begin
         bad++; $display("FAIL centre_edge got=%0d->%0d exp=5->9", (src_q.size() > 0 ? src_q[0] : -1), (dst_q.size() > 0 ? dst_q[0] : -1));
      end
      total++; if (rd_q.size() != 25) begin bad++; $display("FAIL centre_reads got=%0d exp=25", rd_q.size()); end
   endtask

   task automatic test_corner();
      bit ok;
      int exp_addr [10] = '{0, 1, 32, 2, 33, 64, 3, 34, 65, 96};
      clear_mem(); clear_obs();
      build_cands(0, 0);
      fill_all_cands(100, 4990);
      run_event(200, 5000, 1'b0, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL corner_timeout got=no_done exp=done"); end
      total++; if (done_val != 10) begin bad++; $display("FAIL corner_done_count got=%0d exp=10", done_val); end
      total++; if (rd_q.size() != 10) begin bad++; $display("FAIL corner_reads got=%0d exp=10", rd_q.size()); end
      total++; if (src_q.size() != 10) begin bad++; $display("FAIL corner_edge_count got=%0d exp=10", src_q.size()); end
      for (int i = 0; i < 10; i++) begin
         total++;
         if ((rd_q.size() > i ? rd_q[i] : -1) != exp_addr[i] ||
             (src_q.size() > i ? src_q[i] : -1) != 100 + exp_addr[i] ||
             (dst_q.size() > i ? dst_q[i] : -1) != 200) begin
            bad++;
            $display("FAIL corner_item%0d got=addr%0d edge%0d->%0d exp=addr%0d edge%0d->200", i,
                     (rd_q.size() > i ? rd_q[i] : -1), (src_q.size() > i ? src_q[i] : -1),
                     (dst_q.size() > i ? dst_q[i] : -1), exp_addr[i], 100 + exp_addr[i]);
         end
      end
   endtask

   task automatic test_all_skip();
      bit ok;
      clear_mem(); clear_obs();
      for (int i = 0; i < int'(MAX_DS_RANGE); i++) cand[i] = pixel_idx_t'(-1);
      run_event(3, 77, 1'b0, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL skip_timeout got=no_done exp=done"); end
      total++; if (rd_q.size() != 0) begin bad++; $display("FAIL skip_reads got=%0d exp=0", rd_q.size()); end
      total++; if (src_q.size() != 0) begin bad++; $display("FAIL skip_edges got=%0d exp=0", src_q.size()); end
      total++; if (done_cyc - acc_cyc != 26) begin bad++; $display("FAIL skip_latency got=%0d exp=26", done_cyc - acc_cyc); end
      total++; if (done_val != 0) begin bad++; $display("FAIL skip_done_count got=%0d exp=0", done_val); end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_mem(); clear_obs();
      build_cands(10, 10);
      fill_all_cands(1000, 4000);
      run_event(50, 4100, 1'b1, 400, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no_done exp=done"); end
      total++; if (done_val != 16) begin bad++; $display("FAIL bp_done_count got=%0d exp=16", done_val); end
      total++; if (src_q.size() != 16) begin bad++; $display("FAIL bp_edge_count got=%0d exp=16", src_q.size()); end
      total++; if (rd_q.size() != 16) begin bad++; $display("FAIL bp_reads got=%0d exp=16", rd_q.size()); end
      for (int i = 0; i < 16; i++) begin
         total++;
         if ((src_q.size() > i ? src_q[i] : -1) != 1000 + int'(cand[i]) ||
             (dst_q.size() > i ? dst_q[i] : -1) != 50) begin
            bad++;
            $display("FAIL bp_edge%0d got=%0d->%0d exp=%0d->50", i, (src_q.size() > i ? src_q[i] : -1),
                     (dst_q.size() > i ? dst_q[i] : -1), 1000 + int'(cand[i]));
         end
      end
      total++; if (stalls == 0) begin bad++; $display("FAIL bp_stalls got=%0d exp=>0", stalls); end
      total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
   endtask

   task automatic test_wrap();
      bit ok;
      clear_mem(); clear_obs();
      build_cands(5, 5);
      set_mem(5, 4, 1'b1, 6, 16777216 - 49990);   // age exactly 50000
      set_mem(6, 5, 1'b1, 3, 16777216 - 5);       // age 15 across wrap
      set_mem(4, 5, 1'b1, 4, 20);                  // future ts, huge age
      set_mem(5, 6, 1'b1, 7, 10);                  // same node as event
      set_mem(5, 7, 1'b1, 8, 16777216 - 49991);   // age 50001
      set_mem(3, 5, 1'b0, 11, 10);                 // unoccupied
      run_event(7, 10, 1'b0, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=no_done exp=done"); end
      total++; if (done_val != 2) begin bad++; $display("FAIL wrap_done_count got=%0d exp=2", done_val); end
      total++; if ((src_q.size() > 0 ? src_q[0] : -1) != 6) begin bad++; $display("FAIL wrap_edge0 got=%0d exp=6", (src_q.size() > 0 ? src_q[0] : -1)); end
      total++; if ((src_q.size() > 1 ? src_q[1] : -1) != 3) begin bad++; $display("FAIL wrap_edge1 got=%0d exp=3", (src_q.size() > 1 ? src_q[1] : -1)); end
   endtask

   task automatic test_reset_emit();
      bit ok, seen;
      int base_acc, base_done;
      clear_mem(); clear_obs();
      set_mem(11, 10, 1'b1, 5, 1000);
      build_cands(10, 10);
      base_acc  = acc_cnt;
      base_done = done_seen;
      bus.edge_ready = 1'b0;
      bus.in_node = 16'd9; bus.in_ts = 24'd1200;
      for (int i = 0; i < int'(MAX_DS_RANGE); i++) bus.in_pixels[i] = cand[i];
      bus.in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (acc_cnt != base_acc) bus.in_valid = 1'b0;
         if (bus.edge_valid) begin seen = 1'b1; break; end
      end
      bus.in_valid = 1'b0;
      total++; if (!seen) begin bad++; $display("FAIL rst_emit_reach got=no_edge_valid exp=edge_valid"); end
      rstn = 1'b0;
      @(posedge clk); @(negedge clk);
      total++; if (bus.edge_valid !== 1'b0) begin bad++; $display("FAIL rst_emit_edge_valid got=%0b exp=0", bus.edge_valid); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_emit_done got=%0b exp=0", bus.done); end
      @(posedge clk); #1 rstn = 1'b1;
      bus.edge_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      total++; if (done_seen != base_done || src_q.size() != 0) begin
         bad++; $display("FAIL rst_emit_aborted got=done%0d_edges%0d exp=done0_edges0", done_seen - base_done, src_q.size());
      end
      clear_obs();
      run_event(9, 1200, 1'b0, 200, ok);
      total++; if (!ok || done_val != 1) begin bad++; $display("FAIL rst_emit_followup_done got=%0d exp=1", done_val); end
      total++; if ((src_q.size() > 0 ? src_q[0] : -1) != 5 || src_q.size() != 1) begin
         bad++; $display("FAIL rst_emit_followup_edge got=%0d(n=%0d) exp=5(n=1)", (src_q.size() > 0 ? src_q[0] : -1), src_q.size());
      end
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_node     = '0;
      bus.in_ts       = '0;
      bus.edge_ready  = 1'b1;
      bus.mem_rd_data = '0;
      for (int i = 0; i < int'(MAX_DS_RANGE); i++) bus.in_pixels[i] = pixel_idx_t'(-1);
      clear_mem();
      test_reset();
      test_centre();
      test_corner();
      test_all_skip();
      test_backpressure();
      test_wrap();
      test_reset_emit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
